// File: rtl/alu_result_uart_tx.sv
// Serialises a captured ALU result byte and a flag byte as two back-to-back UART frames.
// Optional macro PARITY_EN adds an even-parity bit to each frame (8E1 instead of 8N1).
module alu_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       zero,
  input  logic       carry,
  input  logic       overflow,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       dropped
);

  localparam logic [15:0] CNT_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [15:0] r_bit_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_byte_sel;
  logic        r_tx;
  logic        r_busy;
  logic        r_done;
  logic        r_dropped;
  logic [7:0]  r_shadow0;
  logic [7:0]  r_shadow1;

  logic [7:0]  w_cur_byte;
  logic [2:0]  w_next_idx;

  assign w_cur_byte = r_byte_sel ? r_shadow1 : r_shadow0;
  assign w_next_idx = r_bit_idx + 3'd1;

  // NOTE: the shadow registers carry no reset; they are only read after a send has loaded them.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && send) begin
      r_shadow0 <= result;
      r_shadow1 <= {5'b00000, overflow, carry, zero};
    end
  end

  // NOTE: r_done defaults low each cycle so the completion branch yields a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_sel <= 1'b0;
      r_tx       <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (send && r_busy) r_dropped <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_tx <= IDLE_LEVEL;
          if (send) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_dropped  <= 1'b0;
            r_bit_cnt  <= CNT_MAX;
            r_bit_idx  <= '0;
            r_byte_sel <= 1'b0;
          end
        end
        default: begin
          if (r_bit_cnt != '0) begin
            r_bit_cnt <= r_bit_cnt - 16'd1;
          end else begin
            r_bit_cnt <= CNT_MAX;
            case (r_state)
              S_START: begin
                r_state   <= S_DATA;
                r_tx      <= w_cur_byte[0];
                r_bit_idx <= '0;
              end
              S_DATA: begin
                r_bit_idx <= w_next_idx;
                if (r_bit_idx == 3'd7) begin
`ifdef PARITY_EN
                  r_state <= S_PARITY;
                  r_tx    <= ^w_cur_byte;
`else
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
`endif
                end else begin
                  r_tx <= w_cur_byte[w_next_idx];
                end
              end
`ifdef PARITY_EN
              S_PARITY: begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
`endif
              S_STOP: begin
                if (!r_byte_sel) begin
                  // Flag byte starts straight after the result byte's stop bit.
                  r_state    <= S_START;
                  r_byte_sel <= 1'b1;
                  r_tx       <= 1'b0;
                end else begin
                  r_state    <= S_IDLE;
                  r_byte_sel <= 1'b0;
                  r_tx       <= IDLE_LEVEL;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_tx    <= IDLE_LEVEL;
                r_busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign dropped = r_dropped;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx at CLKS_PER_BIT=4; frame length follows PARITY_EN.
module tb_alu_result_uart_tx;

  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int TOTAL = 2 * FB * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       overflow;
  logic       send;
  logic       tx;
  logic       busy;
  logic       done;
  logic       dropped;

  int n_vec  = 0;
  int n_fail = 0;

  logic line [0:255];
  int   busy_cnt;
  int   done_cnt;
  int   done_at;
  logic [15:0] f0;
  logic [15:0] f1;

  alu_result_uart_tx #(.CLKS_PER_BIT(CPB), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .send(send), .tx(tx), .busy(busy), .done(done),
    .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as seen on the line, bit 0 = start bit.
  function automatic logic [15:0] exp_frame(input logic [7:0] b);
    logic [15:0] f;
    f = '0;
    f[8:1] = b;
`ifdef PARITY_EN
    f[9] = ^b;
`endif
    f[FB-1] = 1'b1;
    return f;
  endfunction

  // Called just after a send edge; records tx for n cycles, pulsing send at the given cycles.
  task automatic watch(input int n, input int send_a, input int send_b);
    line[0]  = tx;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= n; c++) begin
      send = (c == send_a) || (c == send_b);
      tick();
      line[c] = tx;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    send = 1'b0;
  endtask

  task automatic get_frames();
    f0 = '0;
    f1 = '0;
    for (int i = 0; i < FB; i++) begin
      f0[i] = line[i * CPB + 2];
      f1[i] = line[FB * CPB + i * CPB + 2];
    end
  endtask

  task automatic pulse_send(input logic [7:0] r, input logic z, input logic c, input logic v);
    result = r; zero = z; carry = c; overflow = v;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; send = 1'b1; result = 8'h77; zero = 1'b1; carry = 1'b1; overflow = 1'b1;

    // Reset held with send asserted: line idle, no status.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", {12'd0, tx, busy, done, dropped}, 16'h8);
    end
    send = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_after_release", {12'd0, tx, busy, done, dropped}, 16'h8);

    // Basic send of 0xA5 with carry; inputs change one cycle later.
    pulse_send(8'hA5, 1'b0, 1'b1, 1'b0);
    check("start_edge_tx_busy", {14'd0, tx, busy}, 16'h1);
    result = 8'h00; carry = 1'b0;
    watch(TOTAL + 2, -1, -1);
    get_frames();
    check("a5_frame0_literal", f0, exp_frame(8'hA5));
`ifndef PARITY_EN
    check("a5_frame0_bits", f0, 16'h034A);
    check("02_frame1_bits", f1, 16'h0204);
`else
    check("a5_parity_bit", {15'd0, f0[9]}, 16'h0);
    check("02_parity_bit", {15'd0, f1[9]}, 16'h1);
`endif
    check("flag_frame1", f1, exp_frame(8'h02));
    check("busy_cycles", 16'(busy_cnt), 16'(TOTAL));
    check("done_latency", 16'(done_at), 16'(TOTAL));
    check("done_width", 16'(done_cnt), 16'd1);
    check("dropped_clear", {15'd0, dropped}, 16'h0);
    check("line_idle_after", {15'd0, tx}, 16'h1);

    // Overlap: a send 10 cycles in is dropped; a send in the done cycle is accepted.
    pulse_send(8'h3C, 1'b1, 1'b0, 1'b1);
    result = 8'hFF; zero = 1'b0; overflow = 1'b0;
    watch(TOTAL, 10, -1);
    check("dropped_set", {15'd0, dropped}, 16'h1);
    check("done_while_dropped", 16'(done_at), 16'(TOTAL));
    result = 8'h81; zero = 1'b0; carry = 1'b0; overflow = 1'b0;
    get_frames();
    check("ovl_frame0", f0, exp_frame(8'h3C));
    check("ovl_frame1", f1, exp_frame(8'h05));
    send = 1'b1;
    tick();
    send = 1'b0;
    check("done_cycle_accept", {13'd0, tx, busy, dropped}, 16'h2);
    watch(TOTAL + 1, -1, -1);
    get_frames();
    check("b2b_frame0", f0, exp_frame(8'h81));
    check("b2b_frame1", f1, exp_frame(8'h00));
    check("b2b_done", 16'(done_at), 16'(TOTAL));

    // Held send: only the first cycle is accepted.
    pulse_send(8'hC3, 1'b0, 1'b0, 1'b1);
    result = 8'h11;
    watch(TOTAL + 1, 1, 2);
    get_frames();
    check("held_frame0", f0, exp_frame(8'hC3));
    check("held_frame1", f1, exp_frame(8'h04));
    check("held_dropped", {15'd0, dropped}, 16'h1);

    // Reset in the middle of byte 0 data bits.
    pulse_send(8'h55, 1'b1, 1'b1, 1'b1);
    watch(15, -1, -1);
    rst_n = 1'b0;
    tick();
    check("midreset_outputs", {12'd0, tx, busy, done, dropped}, 16'h8);
    rst_n = 1'b1;
    watch(2 * TOTAL, -1, -1);
    check("midreset_no_done", 16'(done_cnt), 16'd0);
    check("midreset_idle_line", {14'd0, tx, busy}, 16'h2);
    pulse_send(8'h0F, 1'b0, 1'b1, 1'b1);
    watch(TOTAL + 1, -1, -1);
    get_frames();
    check("post_reset_frame0", f0, exp_frame(8'h0F));
    check("post_reset_frame1", f1, exp_frame(8'h06));
    check("post_reset_done", 16'(done_at), 16'(TOTAL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
Downstream consumer of the ALU stage. On a send strobe it captures the 8-bit ALU result and the zero/carry/overflow flags, then serialises them over a UART TX line as two back-to-back 8N1 frames: result byte first, flag byte second. It gives a host-side readout of each ALU operation, alongside the 7-segment flag display, and runs on the undivided system clock.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200 baud); legal range 2..65535
IDLE_LEVEL, 1, level driven on tx when no frame is active

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
result  input  8  ALU result Y
zero  input  1  ALU zero flag
carry  input  1  ALU carry flag
overflow  input  1  ALU overflow flag
send  input  1  single-cycle request to transmit the current result and flags
tx  output  1  UART serial line
busy  output  1  high while a two-byte transfer is in progress
done  output  1  one-cycle pulse when the second stop bit completes
dropped  output  1  sticky; set when send arrives while busy

Behaviour:
- Reset: clk and rst_n only; a single clock with synchronous active-low reset. While rst_n=0 at a rising edge, the following values apply after that edge: tx=IDLE_LEVEL, busy=0, done=0, dropped=0, state=IDLE, all counters 0.
- Capture: send=1 with busy=0 at edge N latches shadow0=result and shadow1={5'b00000, overflow, carry, zero}. At edge N, busy goes to 1 and tx goes to 0 (start bit). Later changes on the inputs have no effect on the transfer.
- FSM states: IDLE -> START -> DATA -> STOP. From STOP, if byte_sel=0, go to START with byte_sel=1. If byte_sel=1, go to IDLE. With PARITY_EN defined, a PARITY state sits between DATA and STOP.
- Each state holds for exactly CLKS_PER_BIT cycles. A bit counter down-counts from CLKS_PER_BIT-1 to 0, then advances.
- DATA sends 8 bits LSB first, using a 3-bit index that wraps 7->0 on exit. Start bit is 0; stop bit is 1.
- No idle gap between the two frames: the byte-1 start bit immediately follows the byte-0 stop bit.
- Total transfer length is 20*CLKS_PER_BIT cycles, or 22*CLKS_PER_BIT with parity.
- Completion: on the edge that ends the byte-1 stop bit, busy goes to 0 and done goes to 1 for one cycle.
- A send in the done cycle is accepted, because busy=0. The next start bit then begins at that edge, so the line has no idle cycle.
- send while busy=1: the request is ignored, the shadow registers are unchanged, and dropped is set. dropped clears only on reset, or on an accepted send while busy=0.
- send held high for several cycles: only the first cycle is accepted; the following cycles set dropped.
- Reset mid-frame: the transfer is abandoned and tx returns to IDLE_LEVEL after the reset edge. No done pulse is produced.
- tx is driven from a register, so there are no combinational glitches.

Optional Feature:
Macro PARITY_EN.
- Defined: each frame carries an even-parity bit after the 8 data bits (8E1). Parity is the XOR of the data byte. A transfer is 22*CLKS_PER_BIT cycles.
- Undefined: plain 8N1 with no PARITY state; a transfer is 20*CLKS_PER_BIT cycles.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with send=1 -> tx=1, busy=0, done=0, dropped=0 throughout; nothing transmitted after release until a new send.
- Basic send (CLKS_PER_BIT=4, no parity): result=0xA5, carry=1, zero=0, overflow=0, pulse send -> tx bit sequence sampled every 4 cycles is 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,0,0,0,0,0,1. done pulses 80 cycles after the send edge; busy is high for exactly 80 cycles.
- Input stability: change result to 0x00 one cycle after send -> transmitted bytes are still 0xA5 and 0x02.
- Overlap: second send 10 cycles into the transfer -> ignored, dropped=1, frame unchanged. A send in the done cycle -> accepted with no idle gap, and dropped clears.
- Reset mid-frame: assert rst_n=0 during DATA of byte 0 -> tx=1 and busy=0 after the edge, no done pulse. The next send transmits cleanly.
- PARITY_EN, CLKS_PER_BIT=4, same 0xA5/0x02 -> parity bits are 0 then 1; done arrives at 88 cycles.
